// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the DMG timer peripheral (cpu_timer):
//   - bus addresses of the DIV/TIMA/TMA/TAC registers
//   - timer_state_e: TIMA overflow/reload sequencing states
//   - tac_bit(): divider bit tapped for each TAC input-clock select
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [15:0] TIMER_ADDR_DIV  = 16'hFF04;
    localparam logic [15:0] TIMER_ADDR_TIMA = 16'hFF05;
    localparam logic [15:0] TIMER_ADDR_TMA  = 16'hFF06;
    localparam logic [15:0] TIMER_ADDR_TAC  = 16'hFF07;

    typedef enum logic [1:0] {
        TimerIdle     = 2'd0,
        TimerOverflow = 2'd1,
        TimerReload   = 2'd2
    } timer_state_e;

    // Divider bit whose falling edge clocks TIMA:
    // 00 -> 4096 Hz, 01 -> 262144 Hz, 10 -> 65536 Hz, 11 -> 16384 Hz
    function automatic logic [3:0] tac_bit(input logic [1:0] rate);
        case (rate)
            2'b00:   tac_bit = 4'd9;
            2'b01:   tac_bit = 4'd3;
            2'b10:   tac_bit = 4'd5;
            default: tac_bit = 4'd7;
        endcase
    endfunction

endpackage

// File: rtl/cpu_timer_tick.sv
// -----------------------------------------------------------------------------
// cpu_timer_tick
// Free-running 16-bit divider plus TIMA tick generation. The tick is the
// falling edge of (TAC[2] & div[tac_bit(TAC[1:0])]), detected against a
// registered copy of that signal.
//
// Optional feature macro: CPU_TIMER_GLITCH_EN
//   defined   : DIV/TAC writes may create a falling edge (DMG-accurate tick).
//   undefined : on a DIV/TAC write the edge register is reloaded with the
//               post-write signal, so such writes never produce a tick.
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   tac            current TAC register (3 bits)
//   tac_next       TAC value after this edge (reflects a committing write)
//   div_write      DIV write commits on this edge (divider cleared)
//   tac_write      TAC write commits on this edge
//   tick           combinational TIMA increment strobe for this edge
//   div_high       div[15:8], the CPU-visible DIV register
// -----------------------------------------------------------------------------
module cpu_timer_tick
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_DIV = 16'hABCC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] tac,
    input  logic [2:0] tac_next,
    input  logic       div_write,
    input  logic       tac_write,
    output logic       tick,
    output logic [7:0] div_high
);

    logic [15:0] div_reg, div_next;
    logic        edge_reg, edge_next;
    logic [3:0]  taps_now;
    logic        sig;

    assign div_next = div_write ? 16'h0000 : div_reg + 16'd1;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_tap_now
            localparam logic [3:0] TAP = tac_bit(2'(gi));
            assign taps_now[gi] = div_reg[TAP];
        end
    endgenerate

    assign sig = tac[2] & taps_now[tac[1:0]];

`ifdef CPU_TIMER_GLITCH_EN
    // Plain edge register: a write that pulls sig low is seen as a tick.
    logic unused_glitch;
    assign unused_glitch = ^{tac_next, tac_write};
    assign edge_next     = sig;
`else
    // Signal value as it will look after this edge, so a write never
    // presents a 1->0 transition to the detector.
    logic [3:0] taps_post;
    logic       sig_post;

    for (gi = 0; gi < 4; gi++) begin : g_tap_post
        localparam logic [3:0] TAP = tac_bit(2'(gi));
        assign taps_post[gi] = div_next[TAP];
    end

    assign sig_post  = tac_next[2] & taps_post[tac_next[1:0]];
    assign edge_next = (div_write | tac_write) ? sig_post : sig;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg  <= RESET_DIV;
            edge_reg <= 1'b0;
        end else begin
            div_reg  <= div_next;
            edge_reg <= edge_next;
        end
    end

    assign tick     = edge_reg & ~sig;
    assign div_high = div_reg[15:8];

endmodule

// File: rtl/cpu_timer.sv
// -----------------------------------------------------------------------------
// cpu_timer
// DMG timer peripheral (DIV/TIMA/TMA/TAC at 0xFF04-0xFF07) on the CPU bus.
// Holds TIMA/TMA/TAC, the overflow -> reload sequencer and the bus decode;
// the divider and tick detection live in cpu_timer_tick.
// Optional feature macro: CPU_TIMER_GLITCH_EN (see cpu_timer_tick).
//
// Ports:
//   clk           4 MHz system clock, one T-cycle per edge
//   reset         asynchronous active-high reset
//   t_cycle       CPU T-cycle phase; writes commit on the edge with t_cycle==3
//   bus_addr      CPU bus address
//   bus_enable    CPU bus access enable
//   bus_write     CPU bus write enable
//   bus_data_in   write data
//   bus_data_out  combinational read data (0xFF when not selected)
//   bus_selected  access targets 0xFF04-0xFF07
//   irq_timer     one-clock pulse while TIMA is reloaded from TMA
// -----------------------------------------------------------------------------
module cpu_timer
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_DIV      = 16'hABCC,
    parameter int          OVERFLOW_DELAY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  t_cycle,
    input  logic [15:0] bus_addr,
    input  logic        bus_enable,
    input  logic        bus_write,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    output logic        bus_selected,
    output logic        irq_timer
);

    localparam int CNT_W = (OVERFLOW_DELAY > 1) ? $clog2(OVERFLOW_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(OVERFLOW_DELAY - 1);

    timer_state_e     state_reg, state_next;
    logic [7:0]       tima_reg, tima_next;
    logic [7:0]       tma_reg, tma_eff;
    logic [2:0]       tac_reg, tac_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic       commit, addr_hit;
    logic       div_write, tima_write, tma_write, tac_write;
    logic       tick;
    logic [7:0] div_high;

    assign addr_hit   = (bus_addr[15:2] == TIMER_ADDR_DIV[15:2]);
    assign commit     = bus_enable & bus_write & (t_cycle == 2'd3);
    assign div_write  = commit & (bus_addr == TIMER_ADDR_DIV);
    assign tima_write = commit & (bus_addr == TIMER_ADDR_TIMA);
    assign tma_write  = commit & (bus_addr == TIMER_ADDR_TMA);
    assign tac_write  = commit & (bus_addr == TIMER_ADDR_TAC);

    // TMA as seen by a reload on this edge: a same-edge TMA write is taken.
    assign tma_eff  = tma_write ? bus_data_in : tma_reg;
    assign tac_next = tac_write ? bus_data_in[2:0] : tac_reg;

    cpu_timer_tick #(
        .RESET_DIV (RESET_DIV)
    ) u_tick (
        .clk       (clk),
        .reset     (reset),
        .tac       (tac_reg),
        .tac_next  (tac_next),
        .div_write (div_write),
        .tac_write (tac_write),
        .tick      (tick),
        .div_high  (div_high)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= TimerIdle;
            tima_reg  <= 8'h00;
            cnt_reg   <= '0;
            tma_reg   <= 8'h00;
            tac_reg   <= 3'b000;
        end else begin
            state_reg <= state_next;
            tima_reg  <= tima_next;
            cnt_reg   <= cnt_next;
            tma_reg   <= tma_eff;
            tac_reg   <= tac_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tima_next  = tima_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            TimerIdle: begin
                if (tima_write) begin
                    tima_next = bus_data_in;        // write beats a same-edge tick
                end else if (tick) begin
                    if (tima_reg == 8'hFF) begin
                        tima_next  = 8'h00;
                        cnt_next   = CNT_INIT;
                        state_next = TimerOverflow;
                    end else begin
                        tima_next = tima_reg + 8'd1;
                    end
                end
            end
            TimerOverflow: begin
                // Ticks are ignored here; a CPU write aborts the reload.
                if (tima_write) begin
                    tima_next  = bus_data_in;
                    state_next = TimerIdle;
                end else if (cnt_reg == '0) begin
                    tima_next  = tma_eff;
                    state_next = TimerReload;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            TimerReload: begin
                // TIMA keeps following TMA for this clock; CPU TIMA writes lost.
                state_next = TimerIdle;
                tima_next  = tma_eff;
                if (tick) begin
                    if (tma_eff == 8'hFF) begin
                        tima_next  = 8'h00;
                        cnt_next   = CNT_INIT;
                        state_next = TimerOverflow;
                    end else begin
                        tima_next = tma_eff + 8'd1;
                    end
                end
            end
            default: state_next = TimerIdle;
        endcase
    end

    assign irq_timer    = (state_reg == TimerReload);
    assign bus_selected = bus_enable & addr_hit & ~reset;

    always_comb begin
        bus_data_out = 8'hFF;
        if (bus_enable && !reset) begin
            case (bus_addr)
                TIMER_ADDR_DIV:  bus_data_out = div_high;
                TIMER_ADDR_TIMA: bus_data_out = tima_reg;
                TIMER_ADDR_TMA:  bus_data_out = tma_reg;
                TIMER_ADDR_TAC:  bus_data_out = {5'b11111, tac_reg};
                default:         bus_data_out = 8'hFF;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_timer.sv
// -----------------------------------------------------------------------------
// tb_cpu_timer
// Self-checking bench for cpu_timer: a register-decode vector table, hand
// sequences for overflow/reload corner cases, DIV-write glitch and async
// reset, and a randomized run against a cycle-level reference model.
// -----------------------------------------------------------------------------
module tb_cpu_timer;

    localparam int D = 4;   // OVERFLOW_DELAY of the instance

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  t_cycle = 2'd0;
    logic [15:0] bus_addr = 16'h0000;
    logic        bus_enable = 1'b0;
    logic        bus_write = 1'b0;
    logic [7:0]  bus_data_in = 8'h00;
    logic [7:0]  bus_data_out;
    logic        bus_selected;
    logic        irq_timer;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_timer dut (
        .clk          (clk),
        .reset        (reset),
        .t_cycle      (t_cycle),
        .bus_addr     (bus_addr),
        .bus_enable   (bus_enable),
        .bus_write    (bus_write),
        .bus_data_in  (bus_data_in),
        .bus_data_out (bus_data_out),
        .bus_selected (bus_selected),
        .irq_timer    (irq_timer)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive, sample outputs (pre-edge state), then cross the edge.
    task automatic xfer(input logic en, input logic wr, input logic [1:0] tcy,
                        input logic [15:0] a, input logic [7:0] d,
                        output logic [7:0] dout, output logic sel, output logic irq);
        bus_enable  = en;
        bus_write   = wr;
        t_cycle     = tcy;
        bus_addr    = a;
        bus_data_in = d;
        #1;
        dout = bus_data_out;
        sel  = bus_selected;
        irq  = irq_timer;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] dout, output logic irq);
        logic s;
        xfer(1'b1, 1'b0, 2'd0, a, 8'h00, dout, s, irq);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        logic [7:0] x;
        logic s, i;
        xfer(1'b1, 1'b1, 2'd3, a, d, x, s, i);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus_enable = 1'b0;
        bus_write = 1'b0;
        t_cycle = 2'd0;
        bus_addr = 16'h0000;
        bus_data_in = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Fast rate (TAC=05), TIMA=FE; returns just after the first 0x00 sample.
    task automatic run_to_overflow(input logic [7:0] tma);
        logic [7:0] v;
        logic i;
        int n;
        do_reset();
        wr(16'hFF07, 8'h05);
        wr(16'hFF06, tma);
        wr(16'hFF05, 8'hFE);
        n = 0;
        rd(16'hFF05, v, i);
        while (v == 8'hFE && n < 64) begin
            rd(16'hFF05, v, i);
            n++;
        end
        check("pre_ovf_ff", v, 8'hFF);
        n = 0;
        rd(16'hFF05, v, i);
        while (v == 8'hFF && n < 64) begin
            rd(16'hFF05, v, i);
            n++;
        end
        check("tick_gap", n + 1, 16);
        check("ovf_zero", v, 8'h00);
    endtask

    // ---------------- reference model ----------------
    int         sel_tab[4] = '{9, 3, 5, 7};
    logic [15:0] m_div;
    logic [7:0]  m_tima, m_tma;
    logic [2:0]  m_tac;
    logic        m_prev;
    int          m_age;      // clocks since overflow edge, -1 when none pending

    function automatic logic m_sig(input logic [2:0] tac, input logic [15:0] div);
        return tac[2] & div[sel_tab[tac[1:0]]];
    endfunction

    function automatic logic [7:0] m_read(input logic en, input logic [15:0] a);
        if (!en) return 8'hFF;
        case (a)
            16'hFF04: return m_div[15:8];
            16'hFF05: return m_tima;
            16'hFF06: return m_tma;
            16'hFF07: return {5'b11111, m_tac};
            default:  return 8'hFF;
        endcase
    endfunction

    task automatic model_step(input logic en, input logic wr_en, input logic [1:0] tcy,
                              input logic [15:0] a, input logic [7:0] d);
        logic commit, w_div, w_tima, w_tma, w_tac, sig, tick;
        logic [7:0] tma_n, tima_n;
        logic [2:0] tac_n;
        logic [15:0] div_n;
        int age_n;
        commit = en && wr_en && (tcy == 2'd3);
        w_div  = commit && a == 16'hFF04;
        w_tima = commit && a == 16'hFF05;
        w_tma  = commit && a == 16'hFF06;
        w_tac  = commit && a == 16'hFF07;
        sig    = m_sig(m_tac, m_div);
        tick   = m_prev && !sig;
        tma_n  = w_tma ? d : m_tma;
        tac_n  = w_tac ? d[2:0] : m_tac;
        div_n  = w_div ? 16'h0000 : m_div + 16'd1;
        tima_n = m_tima;
        age_n  = m_age;
        if (m_age == D) begin
            age_n  = -1;
            tima_n = tma_n;
            if (tick) begin
                if (tma_n == 8'hFF) begin
                    tima_n = 8'h00;
                    age_n  = 0;
                end else begin
                    tima_n = tma_n + 8'd1;
                end
            end
        end else if (m_age >= 0) begin
            if (w_tima) begin
                tima_n = d;
                age_n  = -1;
            end else begin
                age_n = m_age + 1;
                if (age_n == D) tima_n = tma_n;
            end
        end else begin
            if (w_tima) tima_n = d;
            else if (tick) begin
                if (m_tima == 8'hFF) begin
                    tima_n = 8'h00;
                    age_n  = 0;
                end else begin
                    tima_n = m_tima + 8'd1;
                end
            end
        end
`ifdef CPU_TIMER_GLITCH_EN
        m_prev = sig;
`else
        m_prev = (w_div || w_tac) ? m_sig(tac_n, div_n) : sig;
`endif
        m_div  = div_n;
        m_tima = tima_n;
        m_tma  = tma_n;
        m_tac  = tac_n;
        m_age  = age_n;
    endtask

    typedef struct {
        logic        en;
        logic        wr;
        logic [1:0]  tcy;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp_dout;
        logic        exp_sel;
    } vec_t;

    initial begin
        vec_t vecs[19];
        logic [7:0] v, dout;
        logic i, s, irq_seen;
        int z;
        logic [15:0] addrs[7];

        vecs[0]  = '{1'b1, 1'b0, 2'd0, 16'hFF04, 8'h00, 8'hAB, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 16'hFF07, 8'h00, 8'hF8, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 2'd0, 16'hFF10, 8'h00, 8'hFF, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 16'hFF05, 8'h00, 8'h00, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 16'hFF06, 8'h00, 8'h00, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 2'd0, 16'hFF05, 8'h00, 8'hFF, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 2'd3, 16'hFF06, 8'h3C, 8'h00, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 2'd0, 16'hFF06, 8'h00, 8'h3C, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 2'd1, 16'hFF06, 8'h99, 8'h3C, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 2'd0, 16'hFF06, 8'h00, 8'h3C, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 2'd3, 16'hFF07, 8'hFA, 8'hF8, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 2'd0, 16'hFF07, 8'h00, 8'hFA, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 2'd3, 16'hFF05, 8'h10, 8'h00, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 2'd0, 16'hFF05, 8'h00, 8'h10, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 2'd0, 16'hFF03, 8'h00, 8'hFF, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 2'd0, 16'hFF08, 8'h00, 8'hFF, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 2'd2, 16'h7F05, 8'h00, 8'hFF, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 2'd3, 16'hFF04, 8'h77, 8'hAB, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 2'd0, 16'hFF04, 8'h00, 8'h00, 1'b1};

        // ---- register decode table ----
        do_reset();
        check("reset_irq", irq_timer, 1'b0);
        for (int k = 0; k < 19; k++) begin
            xfer(vecs[k].en, vecs[k].wr, vecs[k].tcy, vecs[k].addr, vecs[k].data, dout, s, i);
            $display("vec %0d en=%b wr=%b t=%0d addr=%h data=%h dout=%h sel=%b",
                     k, vecs[k].en, vecs[k].wr, vecs[k].tcy, vecs[k].addr, vecs[k].data, dout, s);
            check($sformatf("vec%0d_dout", k), dout, vecs[k].exp_dout);
            check($sformatf("vec%0d_sel", k), s, vecs[k].exp_sel);
        end

        // ---- overflow window and reload pulse ----
        run_to_overflow(8'h40);
        z = 1;
        rd(16'hFF05, v, i);
        while (v == 8'h00 && i == 1'b0 && z < 20) begin
            z++;
            rd(16'hFF05, v, i);
        end
        check("zero_window", z, D);
        check("reload_val", v, 8'h40);
        check("reload_irq", i, 1'b1);
        rd(16'hFF05, v, i);
        check("post_reload_val", v, 8'h40);
        check("irq_one_clk", i, 1'b0);
        $display("seq overflow: zeros=%0d reload=%h", z, 8'h40);

        // ---- TIMA write during overflow cancels reload ----
        run_to_overflow(8'h40);
        wr(16'hFF05, 8'h12);
        irq_seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rd(16'hFF05, v, i);
            irq_seen |= i;
        end
        check("cancel_val", v, 8'h12);
        check("cancel_no_irq", irq_seen, 1'b0);
        $display("seq cancel: tima=%h irq_seen=%b", v, irq_seen);

        // ---- TMA write on reload edge ----
        run_to_overflow(8'h40);
        for (int k = 0; k < D - 1; k++) rd(16'hFF05, v, i);
        xfer(1'b1, 1'b1, 2'd3, 16'hFF06, 8'h77, dout, s, i);
        check("rl_tma_irq", i, 1'b1);
        rd(16'hFF05, v, i);
        check("rl_tma_val", v, 8'h77);
        $display("seq reload+tma write: tima=%h", v);

        // ---- TIMA write on reload edge is ignored ----
        run_to_overflow(8'h40);
        for (int k = 0; k < D - 1; k++) rd(16'hFF05, v, i);
        xfer(1'b1, 1'b1, 2'd3, 16'hFF05, 8'h55, dout, s, i);
        check("rl_tima_irq", i, 1'b1);
        rd(16'hFF05, v, i);
        check("rl_tima_val", v, 8'h40);
        $display("seq reload+tima write: tima=%h", v);

        // ---- DIV write with div[9]=1, TAC=04 ----
        do_reset();
        wr(16'hFF07, 8'h04);
        wr(16'hFF05, 8'h20);
        rd(16'hFF04, v, i);
        check("glitch_pre_div", v, 8'hAB);
        wr(16'hFF04, 8'h5A);
        rd(16'hFF04, v, i);
        check("div_cleared", v, 8'h00);
        rd(16'hFF05, v, i);
`ifdef CPU_TIMER_GLITCH_EN
        check("div_glitch_tima", v, 8'h21);
`else
        check("div_glitch_tima", v, 8'h20);
`endif
        $display("seq div write: tima=%h", v);

        // ---- async reset mid-overflow ----
        run_to_overflow(8'h40);
        rd(16'hFF05, v, i);
        bus_enable = 1'b1;
        bus_write = 1'b0;
        bus_addr = 16'hFF05;
        #2;
        reset = 1'b1;
        #1;
        check("rst_dout", bus_data_out, 8'hFF);
        check("rst_sel", bus_selected, 1'b0);
        check("rst_irq", irq_timer, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        irq_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rd(16'hFF05, v, i);
            irq_seen |= i;
        end
        check("rst_tima", v, 8'h00);
        check("rst_no_irq", irq_seen, 1'b0);
        rd(16'hFF07, v, i);
        check("rst_tac", v, 8'hF8);
        rd(16'hFF04, v, i);
        check("rst_div", v, 8'hAB);
        $display("seq async reset: tima=00 irq_seen=%b", irq_seen);

        // ---- randomized run against the model ----
        addrs = '{16'hFF04, 16'hFF05, 16'hFF06, 16'hFF07, 16'hFF03, 16'hFF08, 16'h0005};
        do_reset();
        m_div = 16'hABCC; m_tima = 8'h00; m_tma = 8'h00; m_tac = 3'b000;
        m_prev = 1'b0; m_age = -1;
        for (int c = 0; c < 3000; c++) begin
            logic en, wre;
            logic [1:0] tcy;
            logic [15:0] a;
            logic [7:0] d;
            int r;
            r = $urandom_range(0, 99);
            d = 8'($urandom);
            if (r < 12) begin
                a = 16'hFF04 + 16'($urandom_range(0, 3));
                if (a == 16'hFF05 && $urandom_range(0, 1) == 1) d = 8'hF8 | 8'($urandom_range(0, 7));
                if (a == 16'hFF07 && $urandom_range(0, 3) != 0) d[2] = 1'b1;
                en  = 1'b1;
                wre = 1'b1;
                tcy = (r < 4) ? 2'd3 : 2'($urandom_range(0, 2));
            end else begin
                a   = addrs[$urandom_range(0, 6)];
                en  = ($urandom_range(0, 9) != 0);
                wre = 1'b0;
                tcy = 2'($urandom_range(0, 3));
            end
            xfer(en, wre, tcy, a, d, dout, s, i);
            check("rand_dout", dout, m_read(en, a));
            check("rand_sel", s, en && a[15:2] == 14'h3FC1);
            check("rand_irq", i, m_age == D);
            if (en && wre && tcy == 2'd3)
                $display("rand cyc %0d write %h <= %h", c, a, d);
            model_step(en, wre, tcy, a, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_timer.md
Name: cpu_timer

Overview:
DMG timer peripheral (DIV/TIMA/TMA/TAC) sitting on the CPU system bus, directly downstream of the CPU's memory port.
- Decodes CPU bus accesses to 0xFF04–0xFF07 and returns read data.
- Produces the timer interrupt request consumed by the interrupt logic feeding the CPU.
- Runs on the CPU's 4 MHz clock and uses the CPU's t_cycle phase for write commit.

Parameters:
RESET_DIV, 16'hABCC, internal divider value after reset (post-boot-ROM DMG state).
OVERFLOW_DELAY, 4, clocks TIMA reads 0x00 between overflow and TMA reload.

Ports:
clk  in  1  system clock (4 MHz, one T-cycle per edge)
reset  in  1  asynchronous, active-high reset
t_cycle  in  2  CPU T-cycle phase; writes commit on the edge where t_cycle==3
bus_addr  in  16  CPU bus address
bus_enable  in  1  CPU bus access enable
bus_write  in  1  CPU bus write enable
bus_data_in  in  8  write data from CPU
bus_data_out  out  8  read data to CPU (combinational)
bus_selected  out  1  high when bus_enable and bus_addr in 0xFF04–0xFF07
irq_timer  out  1  one-clock pulse on TIMA reload

Behaviour:
- Reset is asynchronous, active-high, on clk/reset. Reset values:
  - div=RESET_DIV; TIMA=0x00, TMA=0x00, TAC=3'b000; state=Idle; edge register=0.
  - irq_timer=0, bus_selected=0, bus_data_out=0xFF.
- Reset asserted mid-overflow returns the block to Idle with no IRQ.
- Divider: 16-bit, +1 every clk, wraps 0xFFFF→0x0000.
- Reads (combinational):
  - 0xFF04 → div[15:8]
  - 0xFF05 → TIMA
  - 0xFF06 → TMA
  - 0xFF07 → {5'b11111, TAC}
  - any other address, or bus_enable=0 → 0xFF
- Write commit: bus_enable & bus_write & t_cycle==3 & address hit.
  - DIV write: div←0, data ignored.
  - TAC write: only bits 2:0 stored.
- Tick source: sig = TAC[2] & div[sel], where sel is 9/3/5/7 for TAC[1:0] = 00/01/10/11 (4096/262144/65536/16384 Hz).
  - sig is registered every clk.
  - tick = prev & !sig (falling edge), evaluated every clk.
- State machine (states Idle, Overflow, Reload):
  - Idle, tick, TIMA!=0xFF → TIMA+1.
  - Idle, tick, TIMA==0xFF → TIMA←0x00; go to Overflow; delay counter←OVERFLOW_DELAY-1.
  - Overflow: counter decrements each clk. At 0 → Reload.
  - Reload: lasts exactly one clk. TIMA←TMA, irq_timer=1, then Idle. A tick in this clk increments the reloaded value (TMA+1).
- Simultaneous events:
  - TIMA write + tick on same edge: write wins, tick lost.
  - TIMA write during Overflow: TIMA←data, go to Idle; reload and IRQ cancelled.
  - TIMA write in the Reload clk: ignored; TMA value loaded.
  - TMA write in the Reload clk: new TMA value is loaded into TIMA.
  - A tick during Overflow is ignored (TIMA already 0x00).
- Glitch behaviour on DIV and TAC writes is governed by the optional feature below.

Optional Feature:
Macro: CPU_TIMER_GLITCH_EN.
- Defined: DMG-accurate glitches. A DIV write while div[sel]=1 and TAC[2]=1, or a TAC write that drops sig from 1 to 0, produces a falling edge and therefore a tick.
- Undefined: on the committing edge of any DIV or TAC write, the edge register is loaded with the post-write sig. No spurious tick is produced.

Decomposition:
- Shared package (cpu_pkg): register address constants TIMER_ADDR_DIV/TIMA/TMA/TAC, the timer_state_e enum (TimerIdle, TimerOverflow, TimerReload), and the TAC bit-select lookup.
- One natural sub-module: cpu_timer_tick.
  - Contains: divider, bit mux, edge register, glitch macro.
  - Outputs: tick and div[15:8].
- cpu_timer keeps the register file, state machine and bus decode.

Test Plan:
1. Reset, then read 0xFF04 → 0xAB; read 0xFF07 → 0xF8; read 0xFF10 → 0xFF with bus_selected=0.
2. TAC=0x05, TMA=0x40, TIMA=0xFE → after 2 ticks (16 clk each) TIMA=0x00 for 4 clk → then TIMA=0x40 with irq_timer high for exactly 1 clk.
3. Overflow as in 2; write TIMA=0x12 during the 0x00 window → TIMA=0x12 and no irq_timer pulse.
4. Write TMA=0x77 on the Reload edge → TIMA=0x77. Separately, write TIMA=0x55 on the Reload edge → TIMA=TMA.
5. TAC=0x04, div[9]=1, write DIV → with CPU_TIMER_GLITCH_EN TIMA+1; without it TIMA unchanged; div[15:8] reads 0x00 in both cases.
6. Assert reset asynchronously mid-Overflow → outputs immediately return to reset values; no irq_timer pulse follows.
